// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard bus: ID tag and redirect towards the controller, PC/latch enables,
// forwarding selects and performance counters back to the pipeline.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned STAGES = 3,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) ();

  localparam int unsigned FW = $clog2(STAGES);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_regwrite;
  logic              id_load;
  logic              redirect;

  logic              pc_we;
  logic              ifid_we;
  logic              if_flush;
  logic              idex_bubble;
  logic [FW-1:0]     fwd_a;
  logic [FW-1:0]     fwd_b;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_regwrite, id_load,
           redirect,
    input  pc_we, ifid_we, if_flush, idex_bubble, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_regwrite, id_load,
           redirect,
    output pc_we, ifid_we, if_flush, idex_bubble, fwd_a, fwd_b, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: tracks per-stage register tags, detects load-use / RAW
// hazards, drives stall/flush controls, EX forwarding selects and stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned STAGES     = 3,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned LOAD_STAGE = 3,
  parameter int unsigned BR_STAGE   = 2,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned CNT_W      = 16
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned FW = $clog2(STAGES);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              useRs;
    logic              useRt;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              load;
  } tagT;

  tagT              tagQ [1:STAGES];
  tagT              tagD [1:STAGES];
  tagT              idTag;
  logic             hazard;
  logic             stall;
  logic             pcWe;
  logic             ifidWe;
  logic             ifFlush;
  logic             bubble;
  logic [FW-1:0]    fwdA;
  logic [FW-1:0]    fwdB;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;

  // Register 0 is hardwired, so it never counts as a produced value.
  function automatic logic isWriter(input tagT t, input logic [REG_AW-1:0] r);
    return t.valid && t.regwrite && (t.dst == r) && (r != '0);
  endfunction

  // Forwarding mode only stalls on loads whose data is not yet latched; stall-only mode
  // waits for every writer except the last stage, which the register file bypasses.
  always_comb begin
    hazard = 1'b0;
    for (int s = 1; s <= int'(STAGES); s++) begin
      if ((FWD_EN != 0) ? (tagQ[s].load && (s < int'(LOAD_STAGE) - 1)) : (s < int'(STAGES))) begin
        if ((bus.id_use_rs && isWriter(tagQ[s], bus.id_rs)) ||
            (bus.id_use_rt && isWriter(tagQ[s], bus.id_rt))) begin
          hazard = 1'b1;
        end
      end
    end
    stall = bus.id_valid && hazard;
  end

  always_comb begin
    pcWe    = 1'b1;
    ifidWe  = 1'b1;
    ifFlush = 1'b0;
    bubble  = 1'b0;
    if (bus.redirect) begin
      ifFlush = 1'b1;
      bubble  = 1'b1;
    end else if (stall) begin
      pcWe   = 1'b0;
      ifidWe = 1'b0;
      bubble = 1'b1;
    end
  end

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    fwdA = '0;
    fwdB = '0;
    if ((FWD_EN != 0) && tagQ[1].valid) begin
      for (int k = int'(STAGES); k >= 2; k--) begin
        if (tagQ[1].useRs && isWriter(tagQ[k], tagQ[1].rs)) fwdA = FW'(k - 1);
        if (tagQ[1].useRt && isWriter(tagQ[k], tagQ[1].rt)) fwdB = FW'(k - 1);
      end
    end
  end

  always_comb begin
    idTag.valid    = bus.id_valid;
    idTag.rs       = bus.id_rs;
    idTag.rt       = bus.id_rt;
    idTag.useRs    = bus.id_use_rs;
    idTag.useRt    = bus.id_use_rt;
    idTag.dst      = bus.id_dst;
    idTag.regwrite = bus.id_regwrite;
    idTag.load     = bus.id_load;

    tagD[1] = (bubble || !bus.id_valid) ? tagT'('0) : idTag;
    for (int k = 2; k <= int'(STAGES); k++) begin
      tagD[k] = tagQ[k-1];
    end
    // Squash everything younger than the resolving branch; the branch moves on.
    if (bus.redirect) begin
      for (int k = 1; k <= int'(BR_STAGE); k++) begin
        tagD[k] = tagT'('0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= int'(STAGES); k++) begin
        tagQ[k] <= tagT'('0);
      end
    end else begin
      for (int k = 1; k <= int'(STAGES); k++) begin
        tagQ[k] <= tagD[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stall && !bus.redirect && (stallCnt != '1)) stallCnt <= stallCnt + 1'b1;
      if (bus.redirect && (flushCnt != '1))           flushCnt <= flushCnt + 1'b1;
    end
  end

  assign bus.pc_we       = pcWe;
  assign bus.ifid_we     = ifidWe;
  assign bus.if_flush    = ifFlush;
  assign bus.idex_bubble = bubble;
  assign bus.fwd_a       = fwdA;
  assign bus.fwd_b       = fwdB;
  assign bus.stall_cnt   = stallCnt;
  assign bus.flush_cnt   = flushCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a forwarding instance (defaults) and a stall-only
// instance with 2-bit counters share clock and reset.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   nTests;
  int   nFail;
  int   expStall;
  int   expFlush;

  pipe_hazard_ctrl_if #(.STAGES(3), .REG_AW(5), .CNT_W(16)) busF ();
  pipe_hazard_ctrl_if #(.STAGES(3), .REG_AW(5), .CNT_W(2))  busS ();

  pipe_hazard_ctrl #(
    .STAGES(3), .REG_AW(5), .LOAD_STAGE(3), .BR_STAGE(2), .FWD_EN(1), .CNT_W(16)
  ) dutF (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busF.slave)
  );

  pipe_hazard_ctrl #(
    .STAGES(3), .REG_AW(5), .LOAD_STAGE(3), .BR_STAGE(2), .FWD_EN(0), .CNT_W(2)
  ) dutS (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (busS.slave)
  );

  // {pc_we, ifid_we, if_flush, idex_bubble}
  logic [3:0] ctrlF;
  logic [3:0] ctrlS;
  logic [3:0] fwdF;
  logic [3:0] fwdS;
  assign ctrlF = {busF.pc_we, busF.ifid_we, busF.if_flush, busF.idex_bubble};
  assign ctrlS = {busS.pc_we, busS.ifid_we, busS.if_flush, busS.idex_bubble};
  assign fwdF  = {busF.fwd_a, busF.fwd_b};
  assign fwdS  = {busS.fwd_a, busS.fwd_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic driveF(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic rw, input logic ld, input logic rdr);
    busF.id_valid = v;   busF.id_rs = rs;         busF.id_rt = rt;
    busF.id_use_rs = urs; busF.id_use_rt = urt;   busF.id_dst = dst;
    busF.id_regwrite = rw; busF.id_load = ld;     busF.redirect = rdr;
  endtask

  task automatic driveS(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] dst,
                        input logic rw, input logic ld, input logic rdr);
    busS.id_valid = v;   busS.id_rs = rs;         busS.id_rt = rt;
    busS.id_use_rs = urs; busS.id_use_rt = urt;   busS.id_dst = dst;
    busS.id_regwrite = rw; busS.id_load = ld;     busS.redirect = rdr;
  endtask

  task automatic idle(input int n);
    driveF(0, 0, 0, 0, 0, 0, 0, 0, 0);
    driveS(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(0);
    #2;
    nTests++;
    if (ctrlF !== 4'b1100) begin nFail++; $display("FAIL reset_ctrl_f: got %b want %b", ctrlF, 4'b1100); end
    nTests++;
    if (ctrlS !== 4'b1100) begin nFail++; $display("FAIL reset_ctrl_s: got %b want %b", ctrlS, 4'b1100); end
    nTests++;
    if (fwdF !== 4'b0000) begin nFail++; $display("FAIL reset_fwd_f: got %b want %b", fwdF, 4'b0000); end
    nTests++;
    if ({busF.stall_cnt, busF.flush_cnt} !== 32'd0) begin
      nFail++; $display("FAIL reset_cnt_f: got %0d/%0d want 0/0", busF.stall_cnt, busF.flush_cnt);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc();
    @(negedge clk);
    nTests++;
    if (ctrlF !== 4'b1100) begin nFail++; $display("FAIL post_reset_ctrl: got %b want %b", ctrlF, 4'b1100); end
    nTests++;
    if ({busF.stall_cnt, busF.flush_cnt} !== 32'd0) begin
      nFail++; $display("FAIL post_reset_cnt: got %0d/%0d want 0/0", busF.stall_cnt, busF.flush_cnt);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    driveF(1, 1, 2, 1, 1, 3, 1, 0, 0);   // add r3,r1,r2
    cyc();
    driveF(1, 3, 3, 1, 1, 5, 1, 0, 0);   // sub r5,r3,r3
    @(negedge clk);
    nTests++;
    if (ctrlF !== 4'b1100) begin nFail++; $display("FAIL b2b_no_stall: got %b want %b", ctrlF, 4'b1100); end
    cyc();
    idle(0);
    @(negedge clk);
    nTests++;
    if (fwdF !== {2'd1, 2'd1}) begin nFail++; $display("FAIL b2b_fwd1: got %b want %b", fwdF, {2'd1, 2'd1}); end
    #1 busF.redirect = 1'b1;
    busF.id_valid = 1'b1;
    #1;
    nTests++;
    if (fwdF !== {2'd1, 2'd1}) begin nFail++; $display("FAIL fwd_comb_path: got %b want %b", fwdF, {2'd1, 2'd1}); end
    busF.redirect = 1'b0;
    busF.id_valid = 1'b0;
    idle(4);

    driveF(1, 1, 2, 1, 1, 3, 1, 0, 0);   // add r3
    cyc();
    driveF(1, 1, 2, 1, 1, 7, 1, 0, 0);   // or r7, independent
    cyc();
    driveF(1, 3, 3, 1, 1, 5, 1, 0, 0);   // sub r5,r3,r3
    cyc();
    idle(0);
    @(negedge clk);
    nTests++;
    if (fwdF !== {2'd2, 2'd2}) begin nFail++; $display("FAIL gap_fwd2: got %b want %b", fwdF, {2'd2, 2'd2}); end
    idle(4);

    driveF(1, 1, 2, 1, 1, 3, 1, 0, 0);   // add r3
    cyc();
    driveF(1, 1, 2, 1, 1, 3, 1, 0, 0);   // add r3 again, younger producer
    cyc();
    driveF(1, 3, 3, 1, 0, 5, 1, 0, 0);   // sub reads r3 on rs only
    cyc();
    idle(0);
    @(negedge clk);
    nTests++;
    if (fwdF !== {2'd1, 2'd0}) begin nFail++; $display("FAIL fwd_youngest_rt_off: got %b want %b", fwdF, {2'd1, 2'd0}); end
    idle(4);
  endtask

  task automatic test_load_use();
    driveF(1, 1, 0, 1, 0, 4, 1, 1, 0);   // lw r4
    cyc();
    driveF(1, 4, 2, 1, 1, 6, 1, 0, 0);   // add r6,r4,r2
    @(negedge clk);
    nTests++;
    if (ctrlF !== 4'b0001) begin nFail++; $display("FAIL lu_stall: got %b want %b", ctrlF, 4'b0001); end
    nTests++;
    if (busF.stall_cnt !== 16'd0) begin nFail++; $display("FAIL lu_cnt_before: got %0d want 0", busF.stall_cnt); end
    cyc();
    @(negedge clk);
    nTests++;
    if (ctrlF !== 4'b1100) begin nFail++; $display("FAIL lu_release: got %b want %b", ctrlF, 4'b1100); end
    nTests++;
    if (busF.stall_cnt !== 16'd1) begin nFail++; $display("FAIL lu_cnt_after: got %0d want 1", busF.stall_cnt); end
    cyc();
    idle(0);
    @(negedge clk);
    nTests++;
    if (fwdF !== {2'd2, 2'd0}) begin nFail++; $display("FAIL lu_fwd2: got %b want %b", fwdF, {2'd2, 2'd0}); end
    expStall = 1;
    idle(4);
  endtask

  task automatic test_r0();
    driveF(1, 1, 0, 1, 0, 0, 1, 1, 0);   // lw r0
    cyc();
    driveF(1, 0, 0, 1, 1, 6, 1, 0, 0);   // add r6,r0,r0
    @(negedge clk);
    nTests++;
    if (ctrlF !== 4'b1100) begin nFail++; $display("FAIL r0_no_stall: got %b want %b", ctrlF, 4'b1100); end
    cyc();
    idle(0);
    @(negedge clk);
    nTests++;
    if (fwdF !== 4'b0000) begin nFail++; $display("FAIL r0_no_fwd: got %b want %b", fwdF, 4'b0000); end
    nTests++;
    if (busF.stall_cnt !== 16'(expStall)) begin
      nFail++; $display("FAIL r0_cnt: got %0d want %0d", busF.stall_cnt, expStall);
    end
    idle(4);
  endtask

  task automatic test_redirect_stall();
    driveF(1, 1, 0, 1, 0, 4, 1, 1, 0);   // lw r4
    cyc();
    driveF(1, 4, 2, 1, 1, 6, 1, 0, 1);   // add r6,r4,r2 with redirect from stage 2
    @(negedge clk);
    nTests++;
    if (ctrlF !== 4'b1111) begin nFail++; $display("FAIL rd_override: got %b want %b", ctrlF, 4'b1111); end
    cyc();
    driveF(1, 4, 6, 1, 1, 8, 1, 0, 0);   // reader of r4 and r6
    expFlush = 1;
    @(negedge clk);
    nTests++;
    if (ctrlF !== 4'b1100) begin nFail++; $display("FAIL rd_no_hazard: got %b want %b", ctrlF, 4'b1100); end
    nTests++;
    if ({busF.stall_cnt, busF.flush_cnt} !== {16'(expStall), 16'(expFlush)}) begin
      nFail++;
      $display("FAIL rd_counters: got %0d/%0d want %0d/%0d", busF.stall_cnt, busF.flush_cnt,
               expStall, expFlush);
    end
    cyc();
    idle(0);
    @(negedge clk);
    nTests++;
    if (fwdF !== 4'b0000) begin nFail++; $display("FAIL rd_squashed: got %b want %b", fwdF, 4'b0000); end
    idle(4);
  endtask

  task automatic test_reset_mid_stall();
    driveF(1, 1, 0, 1, 0, 4, 1, 1, 0);   // lw r4
    cyc();
    driveF(1, 4, 4, 1, 1, 6, 1, 0, 0);   // reader of r4
    @(negedge clk);
    nTests++;
    if (ctrlF !== 4'b0001) begin nFail++; $display("FAIL rst_mid_pre: got %b want %b", ctrlF, 4'b0001); end
    #1 rst_n = 1'b0;
    #1;
    expStall = 0;
    expFlush = 0;
    nTests++;
    if (ctrlF !== 4'b1100) begin nFail++; $display("FAIL rst_mid_ctrl: got %b want %b", ctrlF, 4'b1100); end
    nTests++;
    if ({busF.stall_cnt, busF.flush_cnt} !== 32'd0) begin
      nFail++; $display("FAIL rst_mid_cnt: got %0d/%0d want 0/0", busF.stall_cnt, busF.flush_cnt);
    end
    cyc();
    @(negedge clk);
    #1 rst_n = 1'b1;
    cyc();
    @(negedge clk);
    nTests++;
    if (ctrlF !== 4'b1100) begin nFail++; $display("FAIL rst_release_no_hazard: got %b want %b", ctrlF, 4'b1100); end
    nTests++;
    if (fwdF !== 4'b0000) begin nFail++; $display("FAIL rst_release_fwd: got %b want %b", fwdF, 4'b0000); end
    idle(4);
  endtask

  task automatic test_stall_only();
    driveS(1, 1, 2, 1, 1, 3, 1, 0, 0);   // add r3
    cyc();
    driveS(1, 3, 3, 1, 1, 5, 1, 0, 0);   // sub r5,r3,r3
    @(negedge clk);
    nTests++;
    if (ctrlS !== 4'b0001) begin nFail++; $display("FAIL so_stall1: got %b want %b", ctrlS, 4'b0001); end
    cyc();
    @(negedge clk);
    nTests++;
    if (ctrlS !== 4'b0001) begin nFail++; $display("FAIL so_stall2: got %b want %b", ctrlS, 4'b0001); end
    cyc();
    @(negedge clk);
    nTests++;
    if (ctrlS !== 4'b1100) begin nFail++; $display("FAIL so_proceed: got %b want %b", ctrlS, 4'b1100); end
    nTests++;
    if (busS.stall_cnt !== 2'd2) begin nFail++; $display("FAIL so_cnt2: got %0d want 2", busS.stall_cnt); end
    cyc();
    idle(0);
    @(negedge clk);
    nTests++;
    if (fwdS !== 4'b0000) begin nFail++; $display("FAIL so_fwd_zero: got %b want %b", fwdS, 4'b0000); end
    idle(4);

    driveS(1, 1, 2, 1, 1, 3, 1, 0, 0);   // add r3, then two empty slots
    cyc();
    idle(2);
    driveS(1, 3, 3, 1, 1, 5, 1, 0, 0);   // producer now in the last stage
    @(negedge clk);
    nTests++;
    if (ctrlS !== 4'b1100) begin nFail++; $display("FAIL so_wb_exempt: got %b want %b", ctrlS, 4'b1100); end
    idle(4);

    driveS(1, 1, 2, 1, 1, 3, 1, 0, 0);
    cyc();
    driveS(1, 3, 3, 1, 1, 5, 1, 0, 0);
    cyc();
    cyc();
    @(negedge clk);
    nTests++;
    if (busS.stall_cnt !== 2'd3) begin nFail++; $display("FAIL so_sat: got %0d want 3", busS.stall_cnt); end
    cyc();
    driveS(1, 1, 2, 1, 1, 3, 1, 0, 0);
    cyc();
    driveS(1, 3, 3, 1, 1, 5, 1, 0, 0);
    cyc();
    @(negedge clk);
    nTests++;
    if (busS.stall_cnt !== 2'd3) begin nFail++; $display("FAIL so_no_wrap: got %0d want 3", busS.stall_cnt); end
    idle(4);
  endtask

  initial begin
    nTests   = 0;
    nFail    = 0;
    expStall = 0;
    expFlush = 0;
    test_reset();
    test_back_to_back();
    test_load_use();
    test_r0();
    test_redirect_stall();
    test_reset_mid_stall();
    test_stall_only();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1);
  end

endmodule
